dma_display_reader: RTL and testbench

DMA_DISPLAY_READER -- requirements
Module: dma_display_reader

---
 rtl/dma_display_reader_pkg.sv | 36 +++
 rtl/dma_display_reader_if.sv | 13 +
 rtl/dma_display_fifo.sv | 69 ++++++
 rtl/dma_display_reader.sv | 146 ++++++++++++++
 tb/tb_dma_display_reader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_display_reader_pkg.sv
// Shared types and video mode constants for the DMA display reader.
package dma_display_pkg;

    // Reader control states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // One FIFO entry: the DMA word plus its end-of-frame marker.
    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } fifo_entry_t;

    // Timing of one video mode, in pixels and lines.
    typedef struct packed {
        int width;
        int h_fp;
        int h_sync;
        int h_bp;
        int height;
        int v_fp;
        int v_sync;
        int v_bp;
    } video_mode_t;

    localparam video_mode_t MODE_640X480_60   = '{width: 640,  h_fp: 16, h_sync: 96, h_bp: 48,
                                                  height: 480, v_fp: 10, v_sync: 2,  v_bp: 33};
    localparam video_mode_t MODE_1280X720_60  = '{width: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
                                                  height: 720, v_fp: 5,   v_sync: 5,  v_bp: 20};
    localparam video_mode_t MODE_1920X1080_60 = '{width: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
                                                  height: 1080, v_fp: 4, v_sync: 5,  v_bp: 36};

endpackage

// File: rtl/dma_display_reader_if.sv
// DMA read-stream bus between the memory fetch engine and the display reader.
// Handshake: a word transfers on a rising clock edge where dma_rvalid and
// dma_rready are both high; the master holds dma_rdata/dma_rlast stable while
// dma_rvalid is high and not yet accepted; dma_rready never depends on dma_rvalid.
interface dma_display_reader_if;
    logic        dma_rvalid;
    logic        dma_rready;
    logic [63:0] dma_rdata;
    logic        dma_rlast;

    modport master (output dma_rvalid, output dma_rdata, output dma_rlast, input dma_rready);
    modport slave  (input dma_rvalid, input dma_rdata, input dma_rlast, output dma_rready);
endinterface

// File: rtl/dma_display_fifo.sv
// Synchronous first-word-fall-through FIFO with level output and one-cycle flush.
module dma_display_fifo
    import dma_display_pkg::*;
#(
    parameter int  DEPTH = 512,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  fifo_entry_t   wr_data_i,
    input  logic          rd_en_i,
    output fifo_entry_t   rd_data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_wr, do_rd;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    // Head of queue is always visible; a read just advances the pointer.
    assign rd_data_o = mem_q[rptr_q];

    // Next pointers and level; simultaneous write and read leave the level unchanged.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_wr) wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        if (do_rd) rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
        if (do_wr && !do_rd) level_d = level_q + LW'(1);
        if (!do_wr && do_rd) level_d = level_q - LW'(1);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/dma_display_reader.sv
// Streams two-pixel DMA words through a FIFO onto a raster with de/hs/vs timing.
module dma_display_reader
    import dma_display_pkg::*;
#(
    parameter int  FRAME_WIDTH   = MODE_1280X720_60.width,
    parameter int  FRAME_HEIGHT  = MODE_1280X720_60.height,
    parameter int  H_FP          = MODE_1280X720_60.h_fp,
    parameter int  H_SYNC        = MODE_1280X720_60.h_sync,
    parameter int  H_BP          = MODE_1280X720_60.h_bp,
    parameter int  V_FP          = MODE_1280X720_60.v_fp,
    parameter int  V_SYNC        = MODE_1280X720_60.v_sync,
    parameter int  V_BP          = MODE_1280X720_60.v_bp,
    parameter int  FIFO_DEPTH    = 512,
    parameter int  PREFILL_LEVEL = 256,
    localparam int LW            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       i_pixel_clk,
    input  logic                       rstn,
    input  logic                       i_enable,
    dma_display_reader_if.slave        dma,
    output logic                       o_de,
    output logic                       o_hs,
    output logic                       o_vs,
    output logic [23:0]                o_rgb,
    output logic                       o_underflow,
    output logic                       o_frame_err,
    output state_e                     o_state,
    output logic [LW-1:0]              o_fifo_level
);

    localparam int H_TOTAL = FRAME_WIDTH + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = FRAME_HEIGHT + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(FRAME_WIDTH);
    localparam logic [HW-1:0] H_PIX_LAST = HW'(FRAME_WIDTH - 1);
    localparam logic [HW-1:0] H_SYNC_S   = HW'(FRAME_WIDTH + H_FP);
    localparam logic [HW-1:0] H_SYNC_E   = HW'(FRAME_WIDTH + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(FRAME_HEIGHT);
    localparam logic [VW-1:0] V_PIX_LAST = VW'(FRAME_HEIGHT - 1);
    localparam logic [VW-1:0] V_SYNC_S   = VW'(FRAME_HEIGHT + V_FP);
    localparam logic [VW-1:0] V_SYNC_E   = VW'(FRAME_HEIGHT + V_FP + V_SYNC);

    state_e        state_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic          de_q, hs_q, vs_q, underflow_q, frame_err_q;
    logic [23:0]   rgb_q;

    fifo_entry_t   head;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty, fifo_wr, fifo_flush;
    logic          in_run, active, frame_end, last_pix, pop, prefill_done;
    logic [23:0]   pix;
    logic          unused_bits;

    assign in_run       = (state_q == ST_RUN);
    assign active       = in_run && (h_q < H_ACT) && (v_q < V_ACT);
    assign frame_end    = (h_q == H_LAST) && (v_q == V_LAST);
    assign last_pix     = (h_q == H_PIX_LAST) && (v_q == V_PIX_LAST);
    // The second pixel of a word is consumed on odd h, so the word leaves then.
    assign pop          = active && h_q[0] && !fifo_empty;
    // Leaving RUN drops whatever is queued so the next start begins clean.
    assign fifo_flush   = in_run && frame_end && !i_enable;
    assign prefill_done = (fifo_level >= LW'(PREFILL_LEVEL)) || fifo_full;
    assign pix          = h_q[0] ? head.data[55:32] : head.data[23:0];
    assign unused_bits  = ^{head.data[63:56], head.data[31:24]};

    // Ready is combinational from the registered level, so it drops in the
    // same cycle the FIFO fills; it is also withheld while the flush happens.
    assign dma.dma_rready = (state_q != ST_IDLE) && !fifo_full && !fifo_flush;
    assign fifo_wr        = dma.dma_rvalid && dma.dma_rready;

    dma_display_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (i_pixel_clk),
        .rstn_i    (rstn),
        .flush_i   (fifo_flush),
        .wr_en_i   (fifo_wr),
        .wr_data_i ('{last: dma.dma_rlast, data: dma.dma_rdata}),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .level_o   (fifo_level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Control FSM, raster counters, registered video outputs and sticky flags.
    always_ff @(posedge i_pixel_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            de_q  <= active;
            hs_q  <= in_run && (h_q >= H_SYNC_S) && (h_q < H_SYNC_E);
            vs_q  <= in_run && (v_q >= V_SYNC_S) && (v_q < V_SYNC_E);
            rgb_q <= (active && !fifo_empty) ? pix : '0;
            if (active && fifo_empty) underflow_q <= 1'b1;
            if (pop && (head.last != last_pix)) frame_err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    h_q <= '0;
                    v_q <= '0;
                    if (i_enable) state_q <= ST_PREFILL;
                end
                ST_PREFILL: begin
                    h_q <= '0;
                    v_q <= '0;
                    if (prefill_done) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (frame_end && !i_enable) begin
                        state_q     <= ST_IDLE;
                        h_q         <= '0;
                        v_q         <= '0;
                        underflow_q <= 1'b0;
                        frame_err_q <= 1'b0;
                    end else begin
                        h_q <= (h_q == H_LAST) ? '0 : h_q + HW'(1);
                        if (h_q == H_LAST) v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_de         = de_q;
    assign o_hs         = hs_q;
    assign o_vs         = vs_q;
    assign o_rgb        = rgb_q;
    assign o_underflow  = underflow_q;
    assign o_frame_err  = frame_err_q;
    assign o_state      = state_q;
    assign o_fifo_level = fifo_level;

endmodule

// File: tb/tb_dma_display_reader.sv
// Randomized bench for dma_display_reader with a queue-based reference model.
module tb_dma_display_reader;
  import dma_display_pkg::*;

  localparam int FW = 8, FH = 4, HFP = 2, HSY = 2, HBP = 2, VFP = 1, VSY = 1, VBP = 1;
  localparam int DEPTH = 16, PF = 8;
  localparam int HT = FW + HFP + HSY + HBP;
  localparam int VT = FH + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  logic en;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dma_display_reader_if dma_if ();
  logic        de, hs, vs, uf, fe;
  logic [23:0] rgb;
  state_e      st;
  logic [4:0]  lvl;

  dma_display_reader #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .FIFO_DEPTH(DEPTH), .PREFILL_LEVEL(PF)
  ) dut (
    .i_pixel_clk (clk),
    .rstn        (rstn),
    .i_enable    (en),
    .dma         (dma_if),
    .o_de        (de),
    .o_hs        (hs),
    .o_vs        (vs),
    .o_rgb       (rgb),
    .o_underflow (uf),
    .o_frame_err (fe),
    .o_state     (st),
    .o_fifo_level(lvl)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];   // expected pixel on each de cycle
  logic [12:0] tim_q[$];   // expected {de,hs,vs,uf,fe,rready,state,level} per cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus configuration / driver ----------------
  bit src_on = 0;
  int valid_pct = 100;
  int word_limit = 1000000;
  bit rlast_mode = 0;     // 0: rlast on every 16th word, 1: only on rlast_word
  int rlast_word = 0;
  int word_n = 1;
  bit acc_pend = 0;

  // Word n carries pixels 2n-1 (first) and 2n (second).
  initial begin
    dma_if.dma_rvalid = 1'b0;
    dma_if.dma_rdata  = '0;
    dma_if.dma_rlast  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) word_n = 1;
      else if (acc_pend) word_n++;
      dma_if.dma_rvalid = src_on && rstn && (word_n <= word_limit) &&
                          ($urandom_range(0, 99) < 32'(valid_pct));
      dma_if.dma_rdata  = {32'(2 * word_n), 32'(2 * word_n - 1)};
      dma_if.dma_rlast  = rlast_mode ? (word_n == rlast_word) : (word_n % 16 == 0);
    end
  end

  // ---------------- reference model ----------------
  state_e      m_state = ST_IDLE;
  int          m_t = 0;          // cycle index within the running frame
  logic [64:0] m_q[$];           // words held in the FIFO
  bit          m_uf = 0, m_fe = 0;

  // Advance the model by one clock edge using the inputs visible now.
  task automatic model_step();
    int sz, h, v;
    bit rdy, wr, act, de_n, hs_n, vs_n, rdy_n, ending;
    logic [64:0] head;
    logic [23:0] pix;
    sz = m_q.size();
    ending = (m_state == ST_RUN) && (m_t == FT - 1) && !en;
    rdy = (m_state != ST_IDLE) && (sz < DEPTH) && !ending;
    wr = dma_if.dma_rvalid && rdy;
    de_n = 0; hs_n = 0; vs_n = 0;
    if (m_state == ST_RUN) begin
      h = m_t % HT;
      v = m_t / HT;
      act = (h < FW) && (v < FH);
      de_n = act;
      hs_n = (h >= FW + HFP) && (h < FW + HFP + HSY);
      vs_n = (v >= FH + VFP) && (v < FH + VFP + VSY);
      if (act) begin
        if (sz == 0) begin
          m_uf = 1;
          pix = '0;
        end else begin
          head = m_q[0];
          pix = (h % 2 == 1) ? head[55:32] : head[23:0];
          if (h % 2 == 1) begin
            void'(m_q.pop_front());
            if (head[64] != ((h == FW - 1) && (v == FH - 1))) m_fe = 1;
          end
        end
        exp_q.push_back(pix);
      end
    end
    if (wr) m_q.push_back({dma_if.dma_rlast, dma_if.dma_rdata});
    case (m_state)
      ST_IDLE:    if (en) m_state = ST_PREFILL;
      ST_PREFILL: if (sz >= PF || sz == DEPTH) m_state = ST_RUN;
      default: begin
        if (ending) begin
          m_state = ST_IDLE;
          m_t = 0;
          m_q.delete();
          m_uf = 0;
          m_fe = 0;
        end else begin
          m_t = (m_t + 1) % FT;
        end
      end
    endcase
    rdy_n = (m_state != ST_IDLE) && (m_q.size() < DEPTH) &&
            !((m_state == ST_RUN) && (m_t == FT - 1) && !en);
    tim_q.push_back({de_n, hs_n, vs_n, m_uf, m_fe, rdy_n, m_state, 5'(m_q.size())});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      acc_pend = dma_if.dma_rvalid && dma_if.dma_rready;
      if (!rstn) begin
        m_state = ST_IDLE;
        m_t = 0;
        m_q.delete();
        m_uf = 0;
        m_fe = 0;
      end else begin
        model_step();
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [12:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (rstn && tim_q.size() > 0) begin
        e = tim_q.pop_front();
        chk("timing{de,hs,vs,uf,fe,rdy,st,lvl}",
            32'({de, hs, vs, uf, fe, dma_if.dma_rready, st, lvl}), 32'(e));
        if (de) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pixel: got 0x%06h with no pixel expected at %0t", rgb, $time);
          end else begin
            chk("pixel", 32'(rgb), 32'(exp_q.pop_front()));
          end
        end else begin
          chk("blank_rgb", 32'(rgb), 32'h0);
        end
      end
    end
  end

  // ---------------- sequencer ----------------
  task automatic check_all_zero();
    chk("rst_de", 32'(de), 0);
    chk("rst_hs", 32'(hs), 0);
    chk("rst_vs", 32'(vs), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_uf", 32'(uf), 0);
    chk("rst_fe", 32'(fe), 0);
    chk("rst_rready", 32'(dma_if.dma_rready), 0);
    chk("rst_state", 32'(st), 0);
    chk("rst_level", 32'(lvl), 0);
  endtask

  // Assert reset after an edge, check outputs asynchronously, then release.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    en = 1'b0;
    src_on = 0;
    #1;
    check_all_zero();
    exp_q.delete();
    tim_q.delete();
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic start(input int pct, input int limit, input bit lmode, input int lword);
    valid_pct = pct;
    word_limit = limit;
    rlast_mode = lmode;
    rlast_word = lword;
    src_on = 1;
    en = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    en = 1'b0;
    apply_reset();

    // Continuous data, two frames, then enable dropped mid-frame.
    start(100, 1000000, 0, 0);
    run_cycles(2 * FT + 40);
    en = 1'b0;
    run_cycles(FT + 30);

    // Data stops after 10 words: underflow from the 11th pair on.
    apply_reset();
    start(100, 10, 0, 0);
    run_cycles(FT + 50);
    en = 1'b0;
    run_cycles(FT + 30);

    // Early rlast on word 12: frame error until IDLE.
    apply_reset();
    start(100, 1000000, 1, 12);
    run_cycles(FT + 20);
    en = 1'b0;
    run_cycles(FT + 30);

    // Reset asserted mid-line while running.
    apply_reset();
    start(100, 1000000, 0, 0);
    run_cycles(26);
    apply_reset();

    // Random valid gaps and a random enable drop.
    start(60 + int'($urandom_range(0, 35)), 1000000, 0, 0);
    run_cycles(2 * FT + int'($urandom_range(0, FT - 1)));
    en = 1'b0;
    run_cycles(FT + 30);
    valid_pct = 50;
    en = 1'b1;
    run_cycles(FT + int'($urandom_range(0, FT - 1)));
    en = 1'b0;
    run_cycles(FT + 30);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_pixels: got %0d unconsumed expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
